xbus_arbiter: RTL and testbench
===============================

XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 16, number of active request/grant lanes, range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, max consecutive data-phase cycles before abort, range 2..255.
REQ-003 SHALL have port sig_clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port sig_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sig_request  input  16  per-master bus request; bits >= NUM_MASTERS ignored.
REQ-006 SHALL have port sig_read  input  1  read strobe from the granted master in the address phase.
REQ-007 SHALL have port sig_write  input  1  write strobe from the granted master in the address phase.
REQ-008 SHALL have port sig_bip  input  1  burst in progress from the master in the data phase.
REQ-009 SHALL have port sig_wait  input  1  slave wait in the data phase.
REQ-010 SHALL have port sig_error  input  1  slave error in the data phase.
REQ-011 SHALL have port sig_grant  output  16  one-hot grant, asserted only in the address phase.
REQ-012 SHALL have port sig_start  output  1  marks an arbitration cycle.
REQ-013 SHALL have port arb_state  output  2  current state encoding, for observation.
REQ-014 SHALL have port proto_err  output  1  one-cycle pulse when sig_read and sig_write are both high in the address phase.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse on data-phase watchdog abort.

Function
REQ-016 SHALL implement states IDLE=0, ARB=1, ADDR=2, DATA=3; all outputs SHALL be registered.
REQ-017 IDLE SHALL go to ARB on the first clock edge after reset deasserts.
REQ-018 In ARB, sig_start SHALL be 1, regardless of requests.
REQ-019 ARB with no valid request SHALL stay in ARB.
REQ-020 ARB with any valid request SHALL go to ADDR, setting sig_grant one-hot to the round-robin winner in the same edge.
REQ-021 Round-robin SHALL search from index (last_grant+1) upward, wrap at NUM_MASTERS-1 to 0; last_grant SHALL reset to NUM_MASTERS-1, so master 0 has first priority.
REQ-022 sig_grant SHALL be high for exactly one cycle (ADDR) and zero in all other states.
REQ-023 ADDR with read xor write SHALL go to DATA.
REQ-024 ADDR with neither read nor write (NOP) SHALL go to ARB.
REQ-025 ADDR with read and write both high SHALL pulse proto_err and go to ARB.
REQ-026 In DATA, a transfer SHALL complete on each cycle with sig_wait=0.
REQ-027 DATA SHALL go to ARB when sig_wait=0 and sig_bip=0 (last transfer).
REQ-028 DATA SHALL go to ARB when sig_error=1 and sig_wait=0 (burst aborted), regardless of bip.
REQ-029 A change in request during ADDR/DATA SHALL have no effect until the next ARB cycle.
REQ-030 Latency SHALL be: request high in ARB -> grant on the next cycle; minimum tenure ARB+ADDR+DATA = 3 cycles.

Reset
REQ-031 Reset assertion, including mid-burst, SHALL immediately force state IDLE, sig_grant=0, sig_start=0, proto_err=0, timeout=0, last_grant=NUM_MASTERS-1, and watchdog count 0.
REQ-032 arb_state SHALL read 0 during reset.

Configuration
REQ-033 Macro XBUS_ARBITER_TIMEOUT_EN defined SHALL compile in an 8-bit data-phase cycle counter.
REQ-034 The counter SHALL clear on DATA entry and increment each DATA cycle.
REQ-035 When the count reaches TIMEOUT_CYCLES-1 without completion, the block SHALL pulse timeout and go to ARB.
REQ-036 With XBUS_ARBITER_TIMEOUT_EN undefined, there SHALL be no counter, timeout SHALL be tied 0, and DATA SHALL stay in DATA indefinitely.

Structure
REQ-037 Package xbus_arb_pkg SHALL hold the state enum typedef, XBUS_MAX_MASTERS=16, and the state encoding constants.
REQ-038 Sub-module xbus_rr_picker SHALL hold the combinational round-robin selection (request mask, last_grant -> one-hot winner + index).

Verification
REQ-039 Release reset, request=0x0000 -> start=1 every cycle from cycle 2, grant stays 0x0000.
REQ-040 request=0x0005 held; each tenure is a single write with bip=0, wait=0 -> grants alternate 0x0001, 0x0004, 0x0001; each tenure is 3 cycles.
REQ-041 Granted master drives read=1, bip=1 for 3 cycles then bip=0, wait=1 for 2 cycles mid-burst -> DATA lasts 6 cycles, then ARB with start=1.
REQ-042 ADDR with read=1, write=1 -> proto_err pulses 1 cycle, next state ARB, no DATA.
REQ-043 Defined XBUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, wait held 1 -> timeout pulses after 8 DATA cycles, then ARB.
REQ-044 Reset asserted mid-DATA -> state 0, grant 0x0000 without a clock edge; after release the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/xbus_arb_pkg.sv
// xbus arbiter shared types and constants.
// State encoding is fixed so arb_state can be observed externally.
package xbus_arb_pkg;

    localparam int XBUS_MAX_MASTERS = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_ADDR = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ARB  = ST_ARB,
        ADDR = ST_ADDR,
        DATA = ST_DATA
    } arb_state_t;

endpackage

// File: rtl/xbus_arbiter_if.sv
// xbus arbiter bus bundle: request/strobe inputs and grant/status outputs.
// master = bus-side driver, slave = arbiter side.
interface xbus_arbiter_if;
    import xbus_arb_pkg::*;

    logic [XBUS_MAX_MASTERS-1:0] sig_request;
    logic                        sig_read;
    logic                        sig_write;
    logic                        sig_bip;
    logic                        sig_wait;
    logic                        sig_error;
    logic [XBUS_MAX_MASTERS-1:0] sig_grant;
    logic                        sig_start;
    logic [1:0]                  arb_state;
    logic                        proto_err;
    logic                        timeout;

    modport master (
        output sig_request, sig_read, sig_write,
        output sig_bip, sig_wait, sig_error,
        input  sig_grant, sig_start, arb_state,
        input  proto_err, timeout
    );

    modport slave (
        input  sig_request, sig_read, sig_write,
        input  sig_bip, sig_wait, sig_error,
        output sig_grant, sig_start, arb_state,
        output proto_err, timeout
    );

endinterface

// File: rtl/xbus_rr_picker.sv
// Combinational round-robin picker: searches upward from last_grant+1,
// wrapping at NUM_MASTERS-1; lanes at or above NUM_MASTERS are ignored.
module xbus_rr_picker
    import xbus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 16
) (
    input  logic [XBUS_MAX_MASTERS-1:0] req,
    input  logic [3:0]                  last_grant,
    output logic [XBUS_MAX_MASTERS-1:0] winner,
    output logic [3:0]                  winner_idx,
    output logic                        valid
);

    localparam logic [XBUS_MAX_MASTERS-1:0] LANE_MASK =
        XBUS_MAX_MASTERS'((33'd1 << NUM_MASTERS) - 33'd1);

    logic [XBUS_MAX_MASTERS-1:0] req_m;
    logic [4:0]                  cand;

    assign req_m = req & LANE_MASK;

    always_comb begin
        valid      = 1'b0;
        winner_idx = last_grant;
        cand       = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = {1'b0, last_grant} + 5'(i);
            if (cand >= 5'(NUM_MASTERS)) begin
                cand = cand - 5'(NUM_MASTERS);
            end
            if (!valid && req_m[cand[3:0]]) begin
                valid      = 1'b1;
                winner_idx = cand[3:0];
            end
        end
        winner = valid ? (XBUS_MAX_MASTERS'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/xbus_arbiter.sv
// xbus round-robin arbiter: IDLE -> ARB -> ADDR -> DATA tenure FSM.
// Optional data-phase watchdog: define XBUS_ARBITER_TIMEOUT_EN.
module xbus_arbiter
    import xbus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          sig_clock,
    input  logic          sig_reset,
    xbus_arbiter_if.slave bus
);

    if (NUM_MASTERS < 1 || NUM_MASTERS > XBUS_MAX_MASTERS) begin : g_bad_nm
        $error("xbus_arbiter: NUM_MASTERS out of range");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_to
        $error("xbus_arbiter: TIMEOUT_CYCLES out of range");
    end

    localparam logic [3:0] LAST_RST = 4'(NUM_MASTERS - 1);

    arb_state_t                  state_q, state_d;
    logic [XBUS_MAX_MASTERS-1:0] grant_q;
    logic                        start_q;
    logic                        perr_q, perr_d;
    logic                        tout_q, tout_d;
    logic [3:0]                  last_q;
    logic [XBUS_MAX_MASTERS-1:0] win;
    logic [3:0]                  win_idx;
    logic                        win_vld;
    logic                        done;

    xbus_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req       (bus.sig_request),
        .last_grant(last_q),
        .winner    (win),
        .winner_idx(win_idx),
        .valid     (win_vld)
    );

    // A data cycle ends the tenure on the last beat or an error beat.
    assign done = !bus.sig_wait && (!bus.sig_bip || bus.sig_error);

`ifdef XBUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    logic       wd_hit;

    assign wd_hit = (cnt_q == TO_LAST);

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            cnt_q <= '0;
        end else if (state_q != DATA) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic wd_hit;
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        perr_d  = 1'b0;
        tout_d  = 1'b0;
        unique case (state_q)
            IDLE: state_d = ARB;
            ARB: begin
                if (win_vld) state_d = ADDR;
            end
            ADDR: begin
                if (bus.sig_read ^ bus.sig_write) begin
                    state_d = DATA;
                end else begin
                    perr_d  = bus.sig_read & bus.sig_write;
                    state_d = ARB;
                end
            end
            DATA: begin
                if (done) begin
                    state_d = ARB;
                end else if (wd_hit) begin
                    tout_d  = 1'b1;
                    state_d = ARB;
                end
            end
        endcase
    end

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            start_q <= 1'b0;
            perr_q  <= 1'b0;
            tout_q  <= 1'b0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= (state_d == ADDR) ? win : '0;
            start_q <= (state_d == ARB);
            perr_q  <= perr_d;
            tout_q  <= tout_d;
            if (state_q == ARB && win_vld) begin
                last_q <= win_idx;
            end
        end
    end

    assign bus.sig_grant = grant_q;
    assign bus.sig_start = start_q;
    assign bus.arb_state = state_q;
    assign bus.proto_err = perr_q;
    assign bus.timeout   = tout_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_xbus_arbiter;

    localparam int NM = 12;
    localparam int TO = 8;
`ifdef XBUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    xbus_arbiter_if bus ();

    xbus_arbiter #(
        .NUM_MASTERS   (NM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sig_clock(clk),
        .sig_reset(rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0..3 = idle/arb/addr/data.
    int          m_phase;
    int          m_last;
    int          m_dcnt;
    logic [15:0] m_grant;
    logic        m_start;
    logic        m_perr;
    logic        m_tout;

    task automatic model_reset();
        m_phase = 0;
        m_last  = NM - 1;
        m_dcnt  = 0;
        m_grant = '0;
        m_start = 1'b0;
        m_perr  = 1'b0;
        m_tout  = 1'b0;
    endtask

    task automatic model_step();
        int          nxt;
        logic [15:0] g;
        logic [3:0]  ci;
        nxt    = m_phase;
        g      = '0;
        m_perr = 1'b0;
        m_tout = 1'b0;
        case (m_phase)
            0: nxt = 1;
            1: begin
                for (int k = 1; k <= NM; k++) begin
                    int c;
                    c  = (m_last + k) % NM;
                    ci = c[3:0];
                    if (nxt == 1 && bus.sig_request[ci]) begin
                        nxt    = 2;
                        g      = 16'd1 << c;
                        m_last = c;
                    end
                end
            end
            2: begin
                if (bus.sig_read != bus.sig_write) begin
                    nxt    = 3;
                    m_dcnt = 0;
                end else begin
                    m_perr = bus.sig_read & bus.sig_write;
                    nxt    = 1;
                end
            end
            default: begin
                if (!bus.sig_wait && (!bus.sig_bip || bus.sig_error)) begin
                    nxt = 1;
                end else if (TO_EN && m_dcnt == TO - 1) begin
                    m_tout = 1'b1;
                    nxt    = 1;
                end else begin
                    m_dcnt++;
                end
            end
        endcase
        m_phase = nxt;
        m_grant = g;
        m_start = (nxt == 1);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] r, input logic rd,
                          input logic wr, input logic bp,
                          input logic wt, input logic er);
        bus.sig_request = r;
        bus.sig_read    = rd;
        bus.sig_write   = wr;
        bus.sig_bip     = bp;
        bus.sig_wait    = wt;
        bus.sig_error   = er;
    endtask

    task automatic test_reset();
        set_in(16'h0000, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.arb_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state got %0d want 0", bus.arb_state);
        end
        n_tests++;
        if (bus.sig_grant !== 16'h0000 || bus.sig_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs grant=%h start=%b want 0000/0",
                     bus.sig_grant, bus.sig_start);
        end
        n_tests++;
        if (bus.proto_err !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses perr=%b tout=%b want 0/0",
                     bus.proto_err, bus.timeout);
        end
        rst = 1'b0;
        model_reset();
        step();
        n_tests++;
        if (bus.arb_state !== 2'd1 || bus.sig_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_exit state=%0d start=%b want 1/1",
                     bus.arb_state, bus.sig_start);
        end
    endtask

    task automatic test_idle_requests();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            set_in((i < 5) ? 16'h0000 : 16'hF000, 0, 0, 0, 0, 0);
            step();
            if (bus.sig_start !== 1'b1 || bus.sig_grant !== 16'h0000 ||
                bus.arb_state !== 2'd1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_arb bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_alternate();
        logic [15:0] exp_g [3];
        logic [15:0] got_g [3];
        int          at [3];
        int          ng;
        exp_g[0] = 16'h0001;
        exp_g[1] = 16'h0004;
        exp_g[2] = 16'h0001;
        ng = 0;
        set_in(16'h0005, 0, 1, 0, 0, 0);
        for (int cyc = 0; cyc < 30 && ng < 3; cyc++) begin
            step();
            if (bus.sig_grant !== 16'h0000) begin
                got_g[ng] = bus.sig_grant;
                at[ng]    = cyc;
                ng++;
            end
        end
        n_tests++;
        if (ng != 3) begin
            n_fail++;
            $display("FAIL alt_count got %0d grants want 3", ng);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (got_g[k] !== exp_g[k]) begin
                    n_fail++;
                    $display("FAIL alt_grant%0d got %h want %h",
                             k, got_g[k], exp_g[k]);
                end
            end
            n_tests++;
            if (at[1] - at[0] != 3 || at[2] - at[1] != 3) begin
                n_fail++;
                $display("FAIL alt_tenure got %0d,%0d want 3,3",
                         at[1] - at[0], at[2] - at[1]);
            end
        end
        set_in(16'h0005, 0, 1, 0, 0, 0);
    endtask

    task automatic test_burst();
        logic [5:0] bip_t;
        logic [5:0] wt_t;
        int         dc;
        bip_t = 6'b011111;
        wt_t  = 6'b000110;
        set_in(16'h0002, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20 &&
             !(bus.arb_state == 2'd2 && bus.sig_grant == 16'h0002); k++) begin
            step();
        end
        n_tests++;
        if (bus.arb_state !== 2'd2 || bus.sig_grant !== 16'h0002) begin
            n_fail++;
            $display("FAIL burst_grant state=%0d grant=%h want 2/0002",
                     bus.arb_state, bus.sig_grant);
        end
        step();
        bus.sig_request = 16'h0000;
        dc = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.arb_state == 2'd3) dc++;
            bus.sig_bip  = bip_t[i];
            bus.sig_wait = wt_t[i];
            step();
        end
        n_tests++;
        if (dc != 6) begin
            n_fail++;
            $display("FAIL burst_len got %0d data cycles want 6", dc);
        end
        n_tests++;
        if (bus.arb_state !== 2'd1 || bus.sig_start !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_end state=%0d start=%b want 1/1",
                     bus.arb_state, bus.sig_start);
        end
    endtask

    task automatic test_proto_err();
        set_in(16'h0008, 1, 1, 0, 0, 0);
        for (int k = 0; k < 20 &&
             !(bus.arb_state == 2'd2 && bus.sig_grant == 16'h0008); k++) begin
            step();
        end
        n_tests++;
        if (bus.arb_state !== 2'd2 || bus.sig_grant !== 16'h0008) begin
            n_fail++;
            $display("FAIL perr_grant state=%0d grant=%h want 2/0008",
                     bus.arb_state, bus.sig_grant);
        end
        step();
        n_tests++;
        if (bus.proto_err !== 1'b1 || bus.arb_state !== 2'd1) begin
            n_fail++;
            $display("FAIL perr_pulse perr=%b state=%0d want 1/1",
                     bus.proto_err, bus.arb_state);
        end
        bus.sig_request = 16'h0000;
        step();
        n_tests++;
        if (bus.proto_err !== 1'b0 || bus.arb_state !== 2'd1) begin
            n_fail++;
            $display("FAIL perr_clear perr=%b state=%0d want 0/1",
                     bus.proto_err, bus.arb_state);
        end
    endtask

    task automatic test_timeout();
        int dc;
        int tbad;
        set_in(16'h0001, 0, 1, 1, 1, 0);
        for (int k = 0; k < 20 && bus.arb_state != 2'd3; k++) step();
        n_tests++;
        if (bus.arb_state !== 2'd3) begin
            n_fail++;
            $display("FAIL to_enter state=%0d want 3", bus.arb_state);
        end
        bus.sig_request = 16'h0000;
        dc   = 0;
        tbad = 0;
        while (bus.arb_state == 2'd3 && dc < 300) begin
            if (bus.timeout !== 1'b0) tbad++;
            dc++;
            step();
        end
        n_tests++;
        if (tbad != 0) begin
            n_fail++;
            $display("FAIL to_early got %0d pulses in data want 0", tbad);
        end
`ifdef XBUS_ARBITER_TIMEOUT_EN
        n_tests++;
        if (dc != TO) begin
            n_fail++;
            $display("FAIL to_len got %0d data cycles want %0d", dc, TO);
        end
        n_tests++;
        if (bus.timeout !== 1'b1 || bus.arb_state !== 2'd1) begin
            n_fail++;
            $display("FAIL to_pulse tout=%b state=%0d want 1/1",
                     bus.timeout, bus.arb_state);
        end
        step();
        n_tests++;
        if (bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear tout=%b want 0", bus.timeout);
        end
`else
        n_tests++;
        if (dc != 300) begin
            n_fail++;
            $display("FAIL to_hold got %0d data cycles want 300", dc);
        end
        bus.sig_wait = 1'b0;
        bus.sig_bip  = 1'b0;
        step();
        n_tests++;
        if (bus.arb_state !== 2'd1 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_release state=%0d tout=%b want 1/0",
                     bus.arb_state, bus.timeout);
        end
`endif
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            bus.sig_request = ($urandom_range(0, 3) == 0) ? 16'h0000
                              : 16'($urandom);
            bus.sig_read  = 1'($urandom_range(0, 1));
            bus.sig_write = 1'($urandom_range(0, 1));
            bus.sig_bip   = 1'($urandom_range(0, 1));
            bus.sig_wait  = ($urandom_range(0, 9) < 4);
            bus.sig_error = ($urandom_range(0, 9) == 0);
            step();
            n_tests++;
            if (bus.arb_state !== 2'(m_phase) || bus.sig_grant !== m_grant ||
                bus.sig_start !== m_start || bus.proto_err !== m_perr ||
                bus.timeout !== m_tout) begin
                n_fail++;
                bad++;
                if (bad < 10) begin
                    $display("FAIL rand_cyc%0d st=%0d g=%h s=%b p=%b t=%b want st=%0d g=%h s=%b p=%b t=%b",
                             i, bus.arb_state, bus.sig_grant, bus.sig_start,
                             bus.proto_err, bus.timeout, m_phase, m_grant,
                             m_start, m_perr, m_tout);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(16'h0030, 0, 1, 1, 1, 0);
        for (int k = 0; k < 30 && bus.arb_state != 2'd3; k++) step();
        step();
        n_tests++;
        if (bus.arb_state !== 2'd3) begin
            n_fail++;
            $display("FAIL rmid_enter state=%0d want 3", bus.arb_state);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.arb_state !== 2'd0 || bus.sig_grant !== 16'h0000 ||
            bus.sig_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async state=%0d grant=%h start=%b want 0/0000/0",
                     bus.arb_state, bus.sig_grant, bus.sig_start);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        bus.sig_wait = 1'b0;
        bus.sig_bip  = 1'b0;
        step();
        step();
        n_tests++;
        if (bus.arb_state !== 2'd2 || bus.sig_grant !== 16'h0010) begin
            n_fail++;
            $display("FAIL rmid_first state=%0d grant=%h want 2/0010",
                     bus.arb_state, bus.sig_grant);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_requests();
        test_alternate();
        test_burst();
        test_proto_err();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
